// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: steps each instruction through fetch, decode,
// execute, memory and writeback, and drives datapath and data-cache strobes.
module cpu_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        run,
    input  logic        Branch,
    input  logic        Uncondbranch,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        RegWrite,
    input  logic        halt,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic [2:0]  state,
    output logic        ir_load,
    output logic        mem_req,
    output logic        mem_we,
    output logic        reg_we,
    output logic        pc_write,
    output logic        pc_src,
    output logic        halted,
    output logic        mem_error,
    output logic [31:0] instr_count
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int unsigned CNT_W  = 32;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6,
        S_ERROR     = 3'd7
    } state_e;

    state_e              state_q, state_d;
    logic                br_q, br_d, ub_q, ub_d, mr_q, mr_d, mw_q, mw_d, rw_q, rw_d;
    logic                taken_q, taken_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic ir_load_q, ir_load_d, mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic reg_we_q, reg_we_d, pc_write_q, pc_write_d, pc_src_q, pc_src_d;
    logic halted_q, halted_d, mem_error_q, mem_error_d;

    // Next-state logic; strobes are registered from the next state so they
    // line up with the state they belong to without any input-to-output path.
    always_comb begin
        state_d = state_q;
        br_d    = br_q;
        ub_d    = ub_q;
        mr_d    = mr_q;
        mw_d    = mw_q;
        rw_d    = rw_q;
        taken_d = taken_q;
        wait_d  = wait_q;
        count_d = count_q;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (halt) begin
                    state_d = S_HALT;
                end else begin
                    br_d    = Branch;
                    ub_d    = Uncondbranch;
                    mr_d    = MemRead;
                    mw_d    = MemWrite;
                    rw_d    = RegWrite;
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                taken_d = ub_q | (br_q & Zero);
                wait_d  = '0;
                state_d = (mr_q | mw_q) ? S_MEMORY : S_WRITEBACK;
            end
            S_MEMORY: begin
                if (mem_ready) begin
                    state_d = S_WRITEBACK;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WRITEBACK: begin
                count_d = count_q + CNT_W'(1);
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_HALT:  state_d = S_HALT;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase

        ir_load_d   = (state_d == S_FETCH);
        mem_req_d   = (state_d == S_MEMORY);
        mem_we_d    = (state_d == S_MEMORY) & mw_d;
        reg_we_d    = (state_d == S_WRITEBACK) & rw_d;
        pc_write_d  = (state_d == S_WRITEBACK);
        pc_src_d    = (state_d == S_WRITEBACK) & taken_d;
        halted_d    = (state_d == S_HALT);
        mem_error_d = (state_d == S_ERROR);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            br_q        <= 1'b0;
            ub_q        <= 1'b0;
            mr_q        <= 1'b0;
            mw_q        <= 1'b0;
            rw_q        <= 1'b0;
            taken_q     <= 1'b0;
            wait_q      <= '0;
            count_q     <= '0;
            ir_load_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            reg_we_q    <= 1'b0;
            pc_write_q  <= 1'b0;
            pc_src_q    <= 1'b0;
            halted_q    <= 1'b0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            br_q        <= br_d;
            ub_q        <= ub_d;
            mr_q        <= mr_d;
            mw_q        <= mw_d;
            rw_q        <= rw_d;
            taken_q     <= taken_d;
            wait_q      <= wait_d;
            count_q     <= count_d;
            ir_load_q   <= ir_load_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            reg_we_q    <= reg_we_d;
            pc_write_q  <= pc_write_d;
            pc_src_q    <= pc_src_d;
            halted_q    <= halted_d;
            mem_error_q <= mem_error_d;
        end
    end

    assign state       = 3'(state_q);
    assign ir_load     = ir_load_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign reg_we      = reg_we_q;
    assign pc_write    = pc_write_q;
    assign pc_src      = pc_src_q;
    assign halted      = halted_q;
    assign mem_error   = mem_error_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: instruction classes, memory wait/timeout,
// halt, run drop and asynchronous reset, against hand-computed expectations.
module tb_cpu_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic        Branch = 1'b0, Uncondbranch = 1'b0, MemRead = 1'b0, MemWrite = 1'b0;
    logic        RegWrite = 1'b0, halt = 1'b0, Zero = 1'b0, mem_ready = 1'b0;
    logic [2:0]  state;
    logic        ir_load, mem_req, mem_we, reg_we, pc_write, pc_src, halted, mem_error;
    logic [31:0] instr_count;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_count = 32'd0;

    cpu_sequencer #(.MEM_TIMEOUT(15)) dut (
        .clock(clock), .reset_n(reset_n), .run(run),
        .Branch(Branch), .Uncondbranch(Uncondbranch), .MemRead(MemRead),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .halt(halt), .Zero(Zero),
        .mem_ready(mem_ready), .state(state), .ir_load(ir_load),
        .mem_req(mem_req), .mem_we(mem_we), .reg_we(reg_we),
        .pc_write(pc_write), .pc_src(pc_src), .halted(halted),
        .mem_error(mem_error), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic clr_flags;
        Branch = 0; Uncondbranch = 0; MemRead = 0; MemWrite = 0; RegWrite = 0;
        halt = 0; Zero = 0;
    endtask

    // Runs one instruction starting in FETCH; mem_ready rises on MEMORY cycle waits+1.
    task automatic do_instr(input string nm, input logic br, input logic ub,
                            input logic mr, input logic mw, input logic rw,
                            input logic zero, input int waits, input logic drop_run,
                            input logic exp_src);
        chk({nm, ".fetch_state"}, 32'(state), 32'd1);
        chk({nm, ".fetch_ir_load"}, 32'(ir_load), 32'd1);
        Branch = br; Uncondbranch = ub; MemRead = mr; MemWrite = mw; RegWrite = rw; Zero = zero;
        step;
        chk({nm, ".decode_state"}, 32'(state), 32'd2);
        chk({nm, ".decode_ir_load"}, 32'(ir_load), 32'd0);
        step;
        chk({nm, ".exec_state"}, 32'(state), 32'd3);
        if (drop_run) run = 1'b0;
        step;
        if (mr | mw) begin
            for (int i = 0; i <= waits; i++) begin
                chk({nm, ".mem_state"}, 32'(state), 32'd4);
                chk({nm, ".mem_req"}, 32'(mem_req), 32'd1);
                chk({nm, ".mem_we"}, 32'(mem_we), 32'(mw));
                if (i == waits) mem_ready = 1'b1;
                step;
            end
            mem_ready = 1'b0;
        end
        chk({nm, ".wb_state"}, 32'(state), 32'd5);
        chk({nm, ".wb_pc_write"}, 32'(pc_write), 32'd1);
        chk({nm, ".wb_pc_src"}, 32'(pc_src), 32'(exp_src));
        chk({nm, ".wb_reg_we"}, 32'(reg_we), 32'(rw));
        chk({nm, ".wb_mem_req"}, 32'(mem_req), 32'd0);
        chk({nm, ".wb_count"}, instr_count, exp_count);
        exp_count = exp_count + 32'd1;
        clr_flags();
        step;
        chk({nm, ".next_state"}, 32'(state), run ? 32'd1 : 32'd0);
        chk({nm, ".retired_count"}, instr_count, exp_count);
        chk({nm, ".next_pc_write"}, 32'(pc_write), 32'd0);
        chk({nm, ".next_reg_we"}, 32'(reg_we), 32'd0);
    endtask

    initial begin
        step;
        step;
        chk("rst.state", 32'(state), 32'd0);
        chk("rst.count", instr_count, 32'd0);
        chk("rst.strobes", 32'({ir_load, mem_req, mem_we, reg_we, pc_write, pc_src, halted, mem_error}), 32'd0);
        reset_n = 1'b1;
        step;
        chk("idle.hold", 32'(state), 32'd0);
        run = 1'b1;
        step;

        do_instr("rtype", 0, 0, 0, 0, 1, 0, 0, 0, 0);
        do_instr("load",  0, 0, 1, 0, 1, 0, 3, 0, 0);
        do_instr("cbz_z1", 1, 0, 0, 0, 0, 1, 0, 0, 1);
        do_instr("cbz_z0", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        do_instr("b_z0",  0, 1, 0, 0, 0, 0, 0, 0, 1);
        do_instr("st_15", 0, 0, 0, 1, 0, 0, 14, 0, 0);
        do_instr("rw_st", 0, 0, 1, 1, 1, 0, 0, 0, 0);
        do_instr("drop",  0, 0, 0, 0, 1, 0, 0, 1, 0);

        step;
        chk("drop.idle_stays", 32'(state), 32'd0);
        run = 1'b1;
        step;

        // Halt wins over other decoder flags and ignores run.
        chk("halt.fetch", 32'(state), 32'd1);
        halt = 1'b1; RegWrite = 1'b1; MemRead = 1'b1;
        step;
        step;
        chk("halt.state", 32'(state), 32'd6);
        chk("halt.halted", 32'(halted), 32'd1);
        chk("halt.pc_write", 32'(pc_write), 32'd0);
        chk("halt.mem_req", 32'(mem_req), 32'd0);
        clr_flags();
        for (int i = 0; i < 4; i++) begin
            run = i[0];
            step;
            chk("halt.sticky", 32'(state), 32'd6);
            chk("halt.count", instr_count, exp_count);
            chk("halt.reg_we", 32'(reg_we), 32'd0);
        end

        #2 reset_n = 1'b0;
        #1;
        chk("halt_rst.state", 32'(state), 32'd0);
        chk("halt_rst.halted", 32'(halted), 32'd0);
        chk("halt_rst.count", instr_count, 32'd0);
        exp_count = 32'd0;
        step;
        reset_n = 1'b1;
        run = 1'b1;
        step;

        // Store with mem_ready stuck low times out into ERROR.
        chk("tmo.fetch", 32'(state), 32'd1);
        MemWrite = 1'b1;
        step;
        step;
        step;
        for (int i = 0; i < 15; i++) begin
            chk("tmo.mem_state", 32'(state), 32'd4);
            chk("tmo.mem_req", 32'(mem_req), 32'd1);
            chk("tmo.mem_we", 32'(mem_we), 32'd1);
            step;
        end
        clr_flags();
        chk("tmo.err_state", 32'(state), 32'd7);
        chk("tmo.mem_error", 32'(mem_error), 32'd1);
        chk("tmo.mem_req_off", 32'(mem_req), 32'd0);
        chk("tmo.count", instr_count, exp_count);
        for (int i = 0; i < 3; i++) begin
            step;
            chk("tmo.sticky", 32'(state), 32'd7);
        end
        #2 reset_n = 1'b0;
        #1;
        chk("tmo_rst.state", 32'(state), 32'd0);
        chk("tmo_rst.mem_error", 32'(mem_error), 32'd0);
        step;
        reset_n = 1'b1;
        step;
        chk("post_rst.fetch", 32'(state), 32'd1);

        // Asynchronous reset in the middle of a memory wait.
        MemRead = 1'b1;
        step;
        step;
        step;
        chk("mid.mem_state", 32'(state), 32'd4);
        chk("mid.mem_req", 32'(mem_req), 32'd1);
        step;
        #2 reset_n = 1'b0;
        #1;
        chk("mid.rst_state", 32'(state), 32'd0);
        chk("mid.rst_mem_req", 32'(mem_req), 32'd0);
        chk("mid.rst_strobes", 32'({ir_load, mem_we, reg_we, pc_write, pc_src, halted, mem_error}), 32'd0);
        clr_flags();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
